// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed seven-segment scan controller
// Host-loaded digit RAM, slot-based scanning with inter-digit blanking and PWM brightness.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_addr,
  input  logic [4:0]            wr_data,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [3:0]            brightness,
  output logic [NUM_DIGITS-1:0] Anode_Activate,
  output logic [6:0]            LED_out,
  output logic                  DP_out,
  output logic [2:0]            scan_idx,
  output logic                  frame_done
);
  localparam int CW  = $clog2(TICK_DIV);
  localparam int SUB = (TICK_DIV - BLANK_CYCLES) / 16;
  localparam logic [CW-1:0] LAST_CNT  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LEN = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] FULL_LEN  = CW'(TICK_DIV - BLANK_CYCLES);

  typedef enum logic [1:0] {ST_BLANK, ST_ON, ST_OFF} slot_state_e;

  slot_state_e           state_q, state_d;
  logic [CW-1:0]         slot_cnt_q, slot_cnt_d;
  logic [2:0]            scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [3:0]            bright_q, bright_d;
  logic                  pending_q, pending_d;
  logic [2:0]            pend_addr_q, pend_addr_d;
  logic [4:0]            pend_data_q, pend_data_d;
  logic [4:0]            ram_q [NUM_DIGITS];
  logic [4:0]            ram_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            led_q, led_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic                  boundary;
  logic [CW-1:0]         on_len;
  logic [2:0]            nxt_idx;
  logic [2:0]            cand;
  logic                  found;
  logic [4:0]            cur;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    boundary     = (slot_cnt_q == LAST_CNT);
    on_len       = (bright_q == 4'hF) ? FULL_LEN : CW'(32'(bright_q) * SUB);
    slot_cnt_d   = boundary ? '0 : slot_cnt_q + CW'(1);
    state_d      = state_q;
    scan_idx_d   = scan_idx_q;
    en_d         = en_q;
    bright_d     = bright_q;
    pending_d    = pending_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    ram_d        = ram_q;
    frame_done_d = 1'b0;
    nxt_idx      = scan_idx_q;
    cand         = '0;
    found        = 1'b0;

    // Circular search starting after the current digit; i == NUM_DIGITS lands back on it.
    for (int i = 1; i <= NUM_DIGITS; i++) begin
      cand = scan_idx_q + 3'(i);
      if (!found && digit_en[cand]) begin
        nxt_idx = cand;
        found   = 1'b1;
      end
    end

    if (boundary) begin
      state_d  = ST_BLANK;
      en_d     = digit_en;
      bright_d = brightness;
      if (found) begin
        scan_idx_d   = nxt_idx;
        frame_done_d = (nxt_idx <= scan_idx_q);
      end
      if (pending_q) begin
        ram_d[pend_addr_q] = pend_data_q;
        pending_d          = 1'b0;
      end
    end else begin
      case (state_q)
        ST_BLANK: if (slot_cnt_q == BLANK_END) state_d = (on_len == '0) ? ST_OFF : ST_ON;
        ST_ON:    if (slot_cnt_q - BLANK_LEN + CW'(1) == on_len) state_d = ST_OFF;
        default:  state_d = state_q;
      endcase
    end

    // Accept only while empty, so an accept never collides with a commit.
    if (wr_valid && !pending_q) begin
      pending_d   = 1'b1;
      pend_addr_d = wr_addr;
      pend_data_d = wr_data;
    end

    cur     = ram_q[scan_idx_q];
    anode_d = '1;
    led_d   = 7'h7F;
    dp_d    = 1'b1;
    if (state_q == ST_ON && en_q[scan_idx_q]) begin
      anode_d[scan_idx_q] = 1'b0;
      led_d               = hex_seg(cur[3:0]);
      dp_d                = ~cur[4];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      slot_cnt_q   <= '0;
      scan_idx_q   <= '0;
      en_q         <= '0;
      bright_q     <= '0;
      pending_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) ram_q[i] <= 5'h00;
      anode_q      <= '1;
      led_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      scan_idx_q   <= scan_idx_d;
      en_q         <= en_d;
      bright_q     <= bright_d;
      pending_q    <= pending_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      ram_q        <= ram_d;
      anode_q      <= anode_d;
      led_q        <= led_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_ready       = ~pending_q;
  assign Anode_Activate = anode_q;
  assign LED_out        = led_q;
  assign DP_out         = dp_q;
  assign scan_idx       = scan_idx_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - directed bench for seven_seg_scan_ctrl
// TICK_DIV=36, BLANK_CYCLES=4 (SUB=2); t tracks slot_cnt as t mod 36.
module tb_seven_seg_scan_ctrl;
  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic [7:0] digit_en;
  logic [3:0] brightness;
  logic [7:0] Anode_Activate;
  logic [6:0] LED_out;
  logic       DP_out;
  logic [2:0] scan_idx;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;
  int acc_t   = -1;
  int busy;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (8),
    .TICK_DIV    (36),
    .BLANK_CYCLES(4)
  ) dut (
    .CLK100MHZ     (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .digit_en      (digit_en),
    .brightness    (brightness),
    .Anode_Activate(Anode_Activate),
    .LED_out       (LED_out),
    .DP_out        (DP_out),
    .scan_idx      (scan_idx),
    .frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected [TB] summary");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock; a write held valid is dropped right after the edge that accepted it.
  task automatic cyc();
    logic acc;
    acc = wr_valid & wr_ready;
    @(negedge clk);
    t++;
    if (acc) begin
      wr_valid = 1'b0;
      acc_t    = t;
    end
  endtask

  task automatic chk_slot(input string tag, input logic [7:0] nxt_en, input logic [3:0] nxt_br,
                          input int e_idx, input int e_on, input logic [7:0] e_an,
                          input logic [6:0] e_led, input logic e_dp, input int e_fd);
    int idx, on_n, fd_n, bad;
    logic [7:0] an;
    logic [6:0] led;
    logic       dp;
    idx = 0; on_n = 0; fd_n = 0; bad = 0; an = 8'hFF; led = 7'h7F; dp = 1'b1;
    for (int k = 0; k < 36; k++) begin
      cyc();
      if (k == 0) begin
        idx        = int'(scan_idx);
        digit_en   = nxt_en;
        brightness = nxt_br;
      end
      if (frame_done) fd_n++;
      if (Anode_Activate != 8'hFF) begin
        if (on_n == 0) begin
          an = Anode_Activate; led = LED_out; dp = DP_out;
        end else if (Anode_Activate !== an || LED_out !== led || DP_out !== dp) begin
          bad++;
        end
        on_n++;
      end else if (LED_out !== 7'h7F || DP_out !== 1'b1) begin
        bad++;
      end
    end
    check_eq({tag, ".idx"}, idx, e_idx);
    check_eq({tag, ".on_cycles"}, on_n, e_on);
    check_eq({tag, ".frame_done"}, fd_n, e_fd);
    check_eq({tag, ".glitch"}, bad, 0);
    if (e_on != 0) begin
      check_eq({tag, ".anode"}, {24'h0, an}, {24'h0, e_an});
      check_eq({tag, ".led"}, {25'h0, led}, {25'h0, e_led});
      check_eq({tag, ".dp"}, {31'h0, dp}, {31'h0, e_dp});
    end
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    digit_en = '0; brightness = '0;
    repeat (3) @(negedge clk);
    check_eq("rst.anode", {24'h0, Anode_Activate}, 32'hFF);
    check_eq("rst.led", {25'h0, LED_out}, 32'h7F);
    check_eq("rst.dp", {31'h0, DP_out}, 32'h1);
    check_eq("rst.wr_ready", {31'h0, wr_ready}, 32'h1);
    check_eq("rst.scan_idx", {29'h0, scan_idx}, 32'h0);
    check_eq("rst.frame_done", {31'h0, frame_done}, 32'h0);

    // Slot 0: digit 1 written first; digit 0 held off until the boundary frees the buffer.
    reset = 1'b0; t = 0;
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 5'h13;
    cyc();
    check_eq("wr1.acc_t", acc_t, 1);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 5'h05;
    digit_en = 8'h03; brightness = 4'hF;
    busy = 0;
    for (int k = 0; k < 35; k++) begin
      if (!wr_ready) busy++;
      cyc();
    end
    check_eq("bp.busy_cycles", busy, 35);
    check_eq("bp.ready_after_boundary", {31'h0, wr_ready}, 32'h1);
    check_eq("s0.frame_done", {31'h0, frame_done}, 32'h0);
    check_eq("s0.scan_idx", {29'h0, scan_idx}, 32'h1);
    check_eq("s0.dark", {24'h0, Anode_Activate}, 32'hFF);

    chk_slot("s1", 8'h03, 4'hF, 1, 32, 8'hFD, 7'h30, 1'b0, 1);
    check_eq("wr2.acc_t", acc_t, 37);
    chk_slot("s2", 8'h03, 4'h8, 0, 32, 8'hFE, 7'h12, 1'b1, 0);
    chk_slot("s3_br8", 8'h03, 4'h0, 1, 16, 8'hFD, 7'h30, 1'b0, 1);
    chk_slot("s4_br0", 8'h91, 4'hF, 0, 0, 8'hFF, 7'h7F, 1'b1, 0);
    chk_slot("s5", 8'h91, 4'hF, 4, 32, 8'hEF, 7'h40, 1'b1, 0);
    chk_slot("s6", 8'h91, 4'hF, 7, 32, 8'h7F, 7'h40, 1'b1, 1);
    chk_slot("s7", 8'h00, 4'hF, 0, 32, 8'hFE, 7'h12, 1'b1, 0);
    chk_slot("s8_none", 8'h00, 4'hF, 0, 0, 8'hFF, 7'h7F, 1'b1, 0);

    // Write accepted exactly in the boundary cycle.
    digit_en = 8'h01; brightness = 4'hF;
    repeat (35) cyc();
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 5'h0A;
    cyc();
    check_eq("bnd.acc_t", acc_t, 360);
    check_eq("bnd.wr_ready", {31'h0, wr_ready}, 32'h0);
    check_eq("bnd.frame_done", {31'h0, frame_done}, 32'h1);
    check_eq("bnd.scan_idx", {29'h0, scan_idx}, 32'h0);
    chk_slot("s10_old", 8'h01, 4'hF, 0, 32, 8'hFE, 7'h12, 1'b1, 1);
    chk_slot("s11_new", 8'h01, 4'hF, 0, 32, 8'hFE, 7'h08, 1'b1, 1);

    // Reset while a write is pending must discard it.
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 5'h1F;
    cyc();
    check_eq("rp.acc_t", acc_t, 433);
    check_eq("rp.wr_ready", {31'h0, wr_ready}, 32'h0);
    cyc(); cyc();
    reset = 1'b1;
    cyc(); cyc();
    check_eq("rp.ready_in_reset", {31'h0, wr_ready}, 32'h1);
    reset = 1'b0; t = 0;
    digit_en = 8'h04; brightness = 4'hF;
    repeat (36) cyc();
    chk_slot("rp.slot", 8'h04, 4'hF, 2, 32, 8'hFB, 7'h40, 1'b1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
